// File: rtl/ysyx_23060124_alu_dispatch.sv
// RV32I integer decode into a one-hot ALU micro-op, registered behind a
// valid/ready handshake with one output register and one skid entry.
`timescale 1ns/1ps

module ysyx_23060124_alu_dispatch #(
    parameter int OPT_WIDTH = 13
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_rs1_data,
    input  logic [31:0]          in_rs2_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_src1,
    output logic [31:0]          out_src2,
    output logic [OPT_WIDTH-1:0] out_opt,
    output logic                 out_if_unsigned,
    output logic [4:0]           out_rd,
    output logic                 out_wen,
    output logic                 out_is_branch,
    output logic                 out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [OPT_WIDTH-1:0] OPT_NONE = OPT_WIDTH'(9'h000);
    localparam logic [OPT_WIDTH-1:0] OPT_ADD  = OPT_WIDTH'(9'h001);
    localparam logic [OPT_WIDTH-1:0] OPT_SUB  = OPT_WIDTH'(9'h002);
    localparam logic [OPT_WIDTH-1:0] OPT_AND  = OPT_WIDTH'(9'h004);
    localparam logic [OPT_WIDTH-1:0] OPT_OR   = OPT_WIDTH'(9'h008);
    localparam logic [OPT_WIDTH-1:0] OPT_XOR  = OPT_WIDTH'(9'h010);
    localparam logic [OPT_WIDTH-1:0] OPT_SLL  = OPT_WIDTH'(9'h020);
    localparam logic [OPT_WIDTH-1:0] OPT_SRL  = OPT_WIDTH'(9'h040);
    localparam logic [OPT_WIDTH-1:0] OPT_SRA  = OPT_WIDTH'(9'h080);
    localparam logic [OPT_WIDTH-1:0] OPT_SLT  = OPT_WIDTH'(9'h100);

    typedef struct packed {
        logic [31:0]          src1;
        logic [31:0]          src2;
        logic [OPT_WIDTH-1:0] opt;
        logic                 if_unsigned;
        logic [4:0]           rd;
        logic                 wen;
        logic                 is_branch;
        logic                 illegal;
    } uop_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rd     = in_inst[11:7];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign shamt  = {27'b0, in_inst[24:20]};

    uop_t dec;
    logic legal;
    logic writes_rd;

    always_comb begin
        dec       = '0;
        legal     = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.src1  = in_rs1_data;
                dec.src2  = in_rs2_data;
                writes_rd = 1'b1;
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  dec.opt = OPT_ADD;
                        3'b001:  dec.opt = OPT_SLL;
                        3'b010:  dec.opt = OPT_SLT;
                        3'b011: begin
                            dec.opt         = OPT_SLT;
                            dec.if_unsigned = 1'b1;
                        end
                        3'b100:  dec.opt = OPT_XOR;
                        3'b101:  dec.opt = OPT_SRL;
                        3'b110:  dec.opt = OPT_OR;
                        default: dec.opt = OPT_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    legal   = 1'b1;
                    dec.opt = OPT_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    legal   = 1'b1;
                    dec.opt = OPT_SRA;
                end
            end
            OPC_OP_IMM: begin
                dec.src1  = in_rs1_data;
                dec.src2  = imm_i;
                writes_rd = 1'b1;
                legal     = 1'b1;
                case (funct3)
                    3'b000: dec.opt = OPT_ADD;
                    3'b010: dec.opt = OPT_SLT;
                    3'b011: begin
                        dec.opt         = OPT_SLT;
                        dec.if_unsigned = 1'b1;
                    end
                    3'b100: dec.opt = OPT_XOR;
                    3'b110: dec.opt = OPT_OR;
                    3'b111: dec.opt = OPT_AND;
                    3'b001: begin
                        // immediate shifts carry only a 5-bit shamt; upper bits must be clean
                        dec.src2 = shamt;
                        dec.opt  = OPT_SLL;
                        legal    = (funct7 == F7_BASE);
                    end
                    default: begin
                        dec.src2 = shamt;
                        dec.opt  = (funct7 == F7_ALT) ? OPT_SRA : OPT_SRL;
                        legal    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                endcase
            end
            OPC_LUI: begin
                dec.src2  = imm_u;
                dec.opt   = OPT_ADD;
                writes_rd = 1'b1;
                legal     = 1'b1;
            end
            OPC_AUIPC: begin
                dec.src1  = in_pc;
                dec.src2  = imm_u;
                dec.opt   = OPT_ADD;
                writes_rd = 1'b1;
                legal     = 1'b1;
            end
            OPC_BRANCH: begin
                dec.src1      = in_rs1_data;
                dec.src2      = in_rs2_data;
                dec.is_branch = 1'b1;
                legal         = 1'b1;
                case (funct3)
                    3'b000, 3'b001: dec.opt = OPT_SUB;
                    3'b100, 3'b101: dec.opt = OPT_SLT;
                    3'b110, 3'b111: begin
                        dec.opt         = OPT_SLT;
                        dec.if_unsigned = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec         = '0;
            dec.opt     = OPT_NONE;
            dec.illegal = 1'b1;
        end
        dec.rd  = rd;
        dec.wen = legal && writes_rd && (rd != 5'd0);
    end

    uop_t out_q;
    uop_t skid_q;
    logic skid_full;
    logic in_fire;

    assign in_fire = in_valid && in_ready;

    // in_ready mirrors !skid_full but is kept as its own flop so it is a clean register output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q     <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            skid_full <= 1'b0;
            in_ready  <= 1'b1;
        end else if (!out_valid || out_ready) begin
            if (skid_full) begin
                out_q     <= skid_q;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
                in_ready  <= 1'b1;
            end else if (in_fire) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q    <= dec;
            skid_full <= 1'b1;
            in_ready  <= 1'b0;
        end
    end

    assign out_src1        = out_q.src1;
    assign out_src2        = out_q.src2;
    assign out_opt         = out_q.opt;
    assign out_if_unsigned = out_q.if_unsigned;
    assign out_rd          = out_q.rd;
    assign out_wen         = out_q.wen;
    assign out_is_branch   = out_q.is_branch;
    assign out_illegal     = out_q.illegal;

endmodule

// File: doc/ysyx_23060124_alu_dispatch.md
YSYX_23060124_ALU_DISPATCH -- requirements
Module: ysyx_23060124_alu_dispatch

Interface
REQ-001 Parameter: OPT_WIDTH, 13, width of the one-hot ALU operation code.
REQ-002 Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
REQ-003 Ports:
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept an instruction.
- in_inst  in  32  RV32I instruction word.
- in_pc  in  32  instruction address.
- in_rs1_data  in  32  rs1 register value.
- in_rs2_data  in  32  rs2 register value.
REQ-004 Ports:
- out_valid  out  1  dispatched operation valid.
- out_ready  in  1  ALU stage accepts.
- out_src1  out  32  ALU operand 1.
- out_src2  out  32  ALU operand 2.
- out_opt  out  OPT_WIDTH  one-hot ALU op.
- out_if_unsigned  out  1  unsigned compare select.
- out_rd  out  5  destination register.
- out_wen  out  1  register write enable.
- out_is_branch  out  1  conditional branch.
- out_illegal  out  1  undecodable instruction.

Function
REQ-005 opt encodings SHALL be: ADD=0x001, SUB=0x002, AND=0x004, OR=0x008, XOR=0x010, SLL=0x020, SRL=0x040, SRA=0x080, SLT=0x100, none=0x000.
REQ-006 OP (0110011): src1=rs1, src2=rs2; funct3/funct7 SHALL select ADD/SUB(funct7=0100000)/SLL/SLT/SLTU/XOR/SRL/SRA(funct7=0100000)/OR/AND; SLTU sets if_unsigned=1, else 0.
REQ-007 OP-IMM (0010011): src1=rs1, src2=sign-extended I-immediate; SLLI/SRLI/SRAI SHALL use src2={27'b0,inst[24:20]}; SLTIU sets if_unsigned=1.
REQ-008 LUI SHALL give ADD, src1=0, src2={inst[31:12],12'b0}; AUIPC SHALL give ADD, src1=in_pc, same src2.
REQ-009 BRANCH (1100011): src1=rs1, src2=rs2, is_branch=1, wen=0; BEQ/BNE→SUB; BLT/BGE→SLT, if_unsigned=0; BLTU/BGEU→SLT, if_unsigned=1; funct3 010/011 illegal.
REQ-010 Illegal SHALL be flagged for any other opcode, OP with funct7 not in {0000000,0100000}, 0100000 with funct3 other than 000/101, or OP-IMM shift with bad inst[31:25].
REQ-011 Illegal instructions SHALL give opt=0x000, wen=0, is_branch=0, src1=src2=0, and still flow through the handshake.
REQ-012 out_wen SHALL be 1 only for legal OP/OP-IMM/LUI/AUIPC with rd≠0; out_rd=inst[11:7] always.
REQ-013 Transfer occurs when valid&&ready on the same edge, on either side.
REQ-014 Latency: an instruction accepted at edge N SHALL appear on out_* with out_valid=1 after edge N, given an empty output register.
REQ-015 Storage SHALL be one output register plus one skid entry; throughput SHALL be one instruction per cycle while out_ready=1.
REQ-016 in_ready SHALL be a register output, equal to !skid_full.
REQ-017 Input accepted while the output register is held (out_valid&&!out_ready) SHALL go to skid; skid SHALL move to output on the next output transfer; order SHALL be preserved.
REQ-018 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-019 Simultaneous output transfer and input accept with skid empty SHALL load the output register directly; no bubble.
REQ-020 Decoding SHALL be registered with the instruction, never driven combinationally from in_*.

Reset
REQ-021 On reset assertion, asynchronously: out_valid=0, skid empty, in_ready=1, out_opt=0, out_wen=0, out_is_branch=0, out_illegal=0, other outputs 0.
REQ-022 Reset mid-transfer SHALL discard output and skid contents; first accept after deassertion behaves per REQ-014.

Verification
REQ-023 in_inst=0x002081B3, rs1=5, rs2=7, out_ready=1 -> next cycle opt=0x001, src1=5, src2=7, rd=3, wen=1.
REQ-024 in_inst=0x40335293 (SRAI x5,x6,3), rs1=0x80000000 -> opt=0x080, src2=3, rd=5, wen=1, illegal=0.
REQ-025 in_inst=0x123450B7 (LUI x1) -> opt=0x001, src1=0, src2=0x12345000, wen=1; in_inst=0x00000000 -> illegal=1, opt=0, wen=0.
REQ-026 out_ready=0, three back-to-back valid instructions A,B,C -> A on output, B in skid, in_ready=0, C held; out_ready=1 -> A,B,C emitted in order on consecutive cycles.
REQ-027 BLTU (0x0020E463) with rs1=1, rs2=2 -> opt=0x100, if_unsigned=1, is_branch=1, wen=0.
REQ-028 Reset pulsed with output and skid full -> out_valid=0, in_ready=1 immediately, no stale instruction emitted afterward.
